// File: rtl/approx_mul_pkg.sv
// ---------------------------------------------------------------------------
// approx_mul_pkg
// Shared types and constants for the sequential approximate multiplier.
//   state_t             : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH       : default operand width
//   DEFAULT_APPROX_COLS : default number of approximately computed columns
//   DEFAULT_CNT_W       : iteration counter width for the default width
//   cntWidth()          : iteration counter width for an arbitrary width
// ---------------------------------------------------------------------------
package approx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_APPROX_COLS = 8;
    localparam int DEFAULT_CNT_W       = $clog2(DEFAULT_WIDTH);

    // A single-bit operand still needs a one-bit counter to exist.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/approx_mul_seq_ctrl_acc_add.sv
// ---------------------------------------------------------------------------
// approx_acc_add
// Combinational 2*WIDTH accumulator adder for the approximate multiplier.
// The low APPROX_COLS columns are compressed with OR (sum = a|b); the carry
// that OR drops from the top approximate column (a&b) is injected into the
// exact upper region. Carry out of the top bit is discarded.
//   acc_i : current accumulator value
//   pp_i  : partial-product row to add
//   sum_o : approximate sum
// ---------------------------------------------------------------------------
module approx_acc_add #(
    parameter int WIDTH       = 16,
    parameter int APPROX_COLS = 8
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] pp_i,
    output logic [2*WIDTH-1:0] sum_o
);

    localparam int PW = 2 * WIDTH;
    localparam int K  = APPROX_COLS;

    // Three shapes: fully exact, fully OR-based, or split at column K.
    generate
        if (K == 0) begin : g_exact
            assign sum_o = acc_i + pp_i;
        end else if (K >= PW) begin : g_allOr
            assign sum_o = acc_i | pp_i;
        end else begin : g_split
            logic          cin;
            logic [PW-K-1:0] cinExt;

            assign cin              = acc_i[K-1] & pp_i[K-1];
            assign cinExt           = (PW-K)'(cin);
            assign sum_o[K-1:0]     = acc_i[K-1:0] | pp_i[K-1:0];
            assign sum_o[PW-1:K]    = acc_i[PW-1:K] + pp_i[PW-1:K] + cinExt;
        end
    endgenerate

endmodule

// File: rtl/approx_mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// approx_mul_seq_ctrl
// Iterative shift-add approximate multiplier controller. One operand pair is
// accepted in IDLE, one partial-product row is accumulated per RUN cycle and
// the result is held in DONE until the consumer takes it.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   in_a, in_b          : unsigned multiplicand / multiplier
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out_p               : approximate 2*WIDTH product
//   busy                : high in RUN or DONE
// Optional build macro APPROX_MUL_EARLY_TERM_EN: finish RUN as soon as the
// remaining multiplier bits are all zero. Results are unchanged.
// ---------------------------------------------------------------------------
module approx_mul_seq_ctrl
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int APPROX_COLS = DEFAULT_APPROX_COLS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cntWidth(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   aOp_q, bOp_q;
    logic [PW-1:0]      acc_q;
    logic [CNT_W-1:0]   count_q;
    logic [PW-1:0]      ppRow;
    logic [PW-1:0]      accSum;
    logic               lastIter;

    // Current partial-product row, taken from the captured operands only.
    assign ppRow = bOp_q[count_q] ? (PW'(aOp_q) << count_q) : '0;

    approx_acc_add #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_accAdd (
        .acc_i (acc_q),
        .pp_i  (ppRow),
        .sum_o (accSum)
    );

    // The shift amount is widened so that count_q+1 = WIDTH does not wrap.
`ifdef APPROX_MUL_EARLY_TERM_EN
    assign lastIter = (count_q == CNT_W'(WIDTH - 1)) ||
                      ((bOp_q >> (32'(count_q) + 32'd1)) == '0);
`else
    assign lastIter = (count_q == CNT_W'(WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The DONE->IDLE edge never accepts new operands
    // because in_ready is only high once the state register shows IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (lastIter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs are pure decodes of the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath: capture operands on accept, accumulate one row per RUN
    // cycle, and leave the accumulator untouched in DONE so out_p holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aOp_q   <= '0;
            bOp_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        aOp_q   <= in_a;
                        bOp_q   <= in_b;
                        acc_q   <= '0;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= accSum;
                    count_q <= count_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_p = acc_q;

endmodule
